fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  IF-stage PC sequencer and instruction buffer between the I_cache and the ID stage.
//  Drives the fetch PC and read request into I_cache. Captures each hit, together with
//  its PC and predictor bit, into an in-order FIFO that ID drains.
//  Decouples ID stalls (load_stall/IsStall) from cache refill latency.
//  On branch misprediction it flushes all entries and restarts from the corrected PC.
// PARAMETERS
//  DEPTH     4      FIFO entries; power of 2, >=2
//  PTR_W     2      log2(DEPTH)
//  RESET_PC  32'h0  fetch_pc value after reset
// PORTS
//  clk          in   1       clock, all state on posedge
//  start        in   1       synchronous active-high reset
//  redirect     in   1       mispredict/jump correction: flush + reload PC
//  redirect_pc  in   32      corrected fetch address; bits[1:0] forced to 0
//  pred_taken   in   1       BHT/BTB prediction for current fetch_pc
//  pred_target  in   32      BTB target for current fetch_pc
//  fetch_pc     out  32      PC presented to I_cache
//  cache_read   out  1       read request to I_cache
//  cache_hit    in   1       I_cache read_hit for fetch_pc, same cycle
//  cache_instr  in   32      I_cache instr for fetch_pc
//  deq_ready    in   1       ID accepts head entry this cycle (0 while stalled)
//  deq_valid    out  1       head entry valid
//  deq_instr    out  32      head instruction; 32'h00000013 (NOP) when empty
//  deq_pc       out  32      head PC; 0 when empty
//  deq_pred     out  1       head prediction bit; 0 when empty
//  count        out  PTR_W+1 occupied entries, 0..DEPTH
// BEHAVIOUR
//  - Reset (start=1): fetch_pc=RESET_PC, count=0, rd_ptr=wr_ptr=0.
//    deq_valid=0 and cache_read=0 during the reset cycle. Reset beats redirect.
//  - cache_read = !start && !redirect && (count<DEPTH). Combinational.
//  - enq = cache_read && cache_hit. The slot takes {fetch_pc, cache_instr, pred_taken}.
//    wr_ptr++ mod DEPTH. Next fetch_pc = pred_taken ? pred_target : fetch_pc+4.
//    The add wraps mod 2^32.
//  - Miss (cache_read && !cache_hit): fetch_pc holds and no entry is written.
//    This continues for however many cycles the refill takes.
//  - deq = deq_valid && deq_ready, with deq_valid = (count!=0) && !redirect.
//    rd_ptr++ mod DEPTH. Head outputs are combinational from the rd_ptr slot.
//  - count_next = count + enq - deq. Simultaneous enq+deq leaves count unchanged.
//  - Full (count==DEPTH): cache_read=0 even if deq that cycle; there is no full-bypass.
//    Fetch resumes the cycle after count<DEPTH.
//  - Empty: no same-cycle bypass. A hit is visible at deq one cycle later.
//  - Redirect: that cycle any hit is discarded and deq is suppressed.
//    Next cycle: count=0, rd_ptr=wr_ptr=0, fetch_pc={redirect_pc[31:2],2'b00}.
//  - Redirect held for several cycles: the queue stays empty and fetch_pc tracks redirect_pc.
//  - FIFO order is strict. Entries are never reordered or duplicated.
// TESTING
//  1 start=1 one cycle -> fetch_pc=0, count=0, deq_valid=0, deq_instr=32'h13, cache_read=1 after.
//  2 hit every cycle, deq_ready=0, instrs A0..A3 -> count=4, fetch_pc=0x10, cache_read=0;
//    a 5th hit is not stored.
//  3 from full, deq_ready=1 -> deq_pc 0,4,8,C in order. First cycle count 4->3 with no enq.
//    Steady state holds count at 3.
//  4 cache_hit=0 for 8 cycles at fetch_pc=0x20 -> fetch_pc holds 0x20, count constant.
//    The 9th-cycle hit enqueues pc 0x20.
//  5 pred_taken=1, pred_target=0x40 at fetch_pc=0x8 -> next fetch_pc=0x40.
//    The entry dequeues with deq_pc=0x8, deq_pred=1.
//  6 count=3, redirect=1, redirect_pc=0x103, simultaneous hit -> next cycle count=0,
//    fetch_pc=0x100, deq_valid=0, hit dropped.

Source files
------------

// File: rtl/fetch_queue.sv
// Purpose : IF-stage PC sequencer plus in-order instruction buffer between I_cache and ID.
// Latency : a cache hit appears at the dequeue head one cycle later (no empty bypass).
// Backpr. : fetch stops while full (no full bypass); a redirect flushes and suppresses dequeue.
//
// Ports
//   clk          clock, all state on posedge
//   start        synchronous active-high reset (wins over redirect)
//   redirect     mispredict/jump correction: flush queue, reload fetch PC
//   redirect_pc  corrected fetch address, low two bits forced to zero
//   pred_taken   predictor taken bit for the current fetch_pc
//   pred_target  predicted target for the current fetch_pc
//   fetch_pc     PC presented to I_cache
//   cache_read   read request to I_cache
//   cache_hit    I_cache hit for fetch_pc, same cycle
//   cache_instr  I_cache instruction for fetch_pc
//   deq_ready    ID accepts the head entry this cycle
//   deq_valid    head entry valid
//   deq_instr    head instruction, NOP (32'h00000013) when empty
//   deq_pc       head PC, 0 when empty
//   deq_pred     head prediction bit, 0 when empty
//   count        occupied entries, 0..DEPTH
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter int          PTR_W    = 2,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic             clk,
   input  logic             start,
   input  logic             redirect,
   input  logic [31:0]      redirect_pc,
   input  logic             pred_taken,
   input  logic [31:0]      pred_target,
   output logic [31:0]      fetch_pc,
   output logic             cache_read,
   input  logic             cache_hit,
   input  logic [31:0]      cache_instr,
   input  logic             deq_ready,
   output logic             deq_valid,
   output logic [31:0]      deq_instr,
   output logic [31:0]      deq_pc,
   output logic             deq_pred,
   output logic [PTR_W:0]   count
);

   localparam logic [31:0]    NOP_INSTR = 32'h0000_0013;
   localparam logic [PTR_W:0] FULL_CNT  = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0] CNT_ONE   = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   // Entry storage. Contents need no reset: only slots below count are ever observed.
   logic [31:0] instr_q [DEPTH];
   logic [31:0] pc_q    [DEPTH];
   logic        pred_q  [DEPTH];

   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [PTR_W:0]   count_q, count_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

   logic empty;
   logic full;
   logic enq;
   logic deq;

   assign empty = (count_q == '0);
   assign full  = (count_q == FULL_CNT);

   // Fetch is gated by the registered occupancy only, so a dequeue in the
   // same cycle as full does not open a slot until the following cycle.
   assign cache_read = !start && !redirect && !full;
   assign enq        = cache_read && cache_hit;

   assign deq_valid  = !start && !redirect && !empty;
   assign deq        = deq_valid && deq_ready;

   assign fetch_pc   = fetch_pc_q;
   assign count      = count_q;

   // Head view straight from the read slot; idle values when nothing is queued.
   always_comb begin
      deq_instr = NOP_INSTR;
      deq_pc    = 32'h0;
      deq_pred  = 1'b0;
      if (!empty) begin
         deq_instr = instr_q[rd_ptr_q];
         deq_pc    = pc_q[rd_ptr_q];
         deq_pred  = pred_q[rd_ptr_q];
      end
   end

   // Next-state for the sequencer and queue bookkeeping.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;

      if (redirect) begin
         // Any hit this cycle is dropped and nothing dequeues; restart clean.
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
      end else begin
         // A miss leaves fetch_pc parked until the refill produces a hit.
         if (enq) begin
            fetch_pc_d = pred_taken ? pred_target : (fetch_pc_q + 32'd4);
            wr_ptr_d   = wr_ptr_q + PTR_ONE;
         end
         if (deq) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         case ({enq, deq})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (start) begin
         fetch_pc_q <= RESET_PC;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   // enq already excludes reset and redirect cycles.
   always_ff @(posedge clk) begin
      if (enq) begin
         instr_q[wr_ptr_q] <= cache_instr;
         pc_q[wr_ptr_q]    <= fetch_pc_q;
         pred_q[wr_ptr_q]  <= pred_taken;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

   localparam int DEPTH = 4;
   localparam int PTR_W = 2;

   logic          clk = 1'b0;
   logic          start;
   logic          redirect;
   logic [31:0]   redirect_pc;
   logic          pred_taken;
   logic [31:0]   pred_target;
   logic [31:0]   fetch_pc;
   logic          cache_read;
   logic          cache_hit;
   logic [31:0]   cache_instr;
   logic          deq_ready;
   logic          deq_valid;
   logic [31:0]   deq_instr;
   logic [31:0]   deq_pc;
   logic          deq_pred;
   logic [PTR_W:0] count;

   fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .RESET_PC(32'h0)) dut (
      .clk         (clk),
      .start       (start),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .pred_taken  (pred_taken),
      .pred_target (pred_target),
      .fetch_pc    (fetch_pc),
      .cache_read  (cache_read),
      .cache_hit   (cache_hit),
      .cache_instr (cache_instr),
      .deq_ready   (deq_ready),
      .deq_valid   (deq_valid),
      .deq_instr   (deq_instr),
      .deq_pc      (deq_pc),
      .deq_pred    (deq_pred),
      .count       (count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        pred;
   } ent_t;

   ent_t        sb[$];
   logic [31:0] m_pc;
   int          m_count;
   int          n_checks;
   int          n_fail;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
      end
   endtask

   // One clock of stimulus. Called just after a posedge; outputs are checked
   // at the following negedge against the reference model, then the model advances.
   task automatic cycle(input logic hit, input logic [31:0] instr, input logic ptk,
                        input logic [31:0] ptgt, input logic rdy, input logic rdr,
                        input logic [31:0] rpc);
      logic exp_rd;
      logic exp_dv;
      ent_t e;
      cache_hit   = hit;
      cache_instr = instr;
      pred_taken  = ptk;
      pred_target = ptgt;
      deq_ready   = rdy;
      redirect    = rdr;
      redirect_pc = rpc;
      @(negedge clk);
      exp_rd = !rdr && (m_count != DEPTH);
      exp_dv = !rdr && (m_count != 0);
      check("cache_read", 32'(cache_read), 32'(exp_rd));
      check("fetch_pc",   fetch_pc,        m_pc);
      check("count",      32'(count),      32'(m_count));
      check("deq_valid",  32'(deq_valid),  32'(exp_dv));
      if (m_count == 0) begin
         check("empty_instr", deq_instr, 32'h0000_0013);
         check("empty_pc",    deq_pc,    32'h0);
      end
      if (exp_dv && rdy) begin
         e = sb.pop_front();
         check("deq_pc",    deq_pc,          e.pc);
         check("deq_instr", deq_instr,       e.instr);
         check("deq_pred",  32'(deq_pred),   32'(e.pred));
         m_count--;
      end
      if (rdr) begin
         sb.delete();
         m_count = 0;
         m_pc    = {rpc[31:2], 2'b00};
      end else if (exp_rd && hit) begin
         sb.push_back('{pc: m_pc, instr: instr, pred: ptk});
         m_count++;
         m_pc = ptk ? ptgt : m_pc + 32'd4;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      start       = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      pred_taken  = 1'b0;
      pred_target = 32'h0;
      cache_hit   = 1'b0;
      cache_instr = 32'h0;
      deq_ready   = 1'b0;

      // Reset cycle: no fetch request, nothing valid.
      @(negedge clk);
      check("rst_cache_read", 32'(cache_read), 32'h0);
      check("rst_deq_valid",  32'(deq_valid),  32'h0);
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      check("post_rst_pc",    fetch_pc,        32'h0);
      check("post_rst_count", 32'(count),      32'h0);
      check("post_rst_dv",    32'(deq_valid),  32'h0);
      check("post_rst_instr", deq_instr,       32'h0000_0013);
      check("post_rst_read",  32'(cache_read), 32'h1);
      m_pc    = 32'h0;
      m_count = 0;
      @(posedge clk);
      #1;

      // Fill with deq stalled; fifth hit must be refused.
      for (int i = 0; i < 5; i++)
         cycle(1'b1, 32'hA000_0000 + 32'(i), 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      check("full_count", 32'(count),      32'h4);
      check("full_pc",    fetch_pc,        32'h10);
      check("full_read",  32'(cache_read), 32'h0);
      @(posedge clk);
      #1;

      // Drain from full with fetch continuing until fetch_pc reaches 0x20.
      for (int i = 0; i < 20 && m_pc != 32'h20; i++)
         cycle(1'b1, 32'hB000_0000 + 32'(i), 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      check("steady_count", 32'(count), 32'h3);

      // Eight-cycle refill at 0x20, then the hit.
      for (int i = 0; i < 8; i++)
         cycle(1'b0, 32'hDEAD_0000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      check("miss_pc_hold", fetch_pc, 32'h20);
      cycle(1'b1, 32'hC000_0020, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 6; i++)
         cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

      // Predicted-taken fetch at 0x8.
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8);
      cycle(1'b1, 32'hD000_0008, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
      check("taken_pc", fetch_pc, 32'h40);
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

      // Redirect at count=3 with a simultaneous hit, then held for a few cycles.
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 32'hE000_0000 + 32'(i), 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      cycle(1'b1, 32'hEEEE_EEEE, 1'b0, 32'h0, 1'b1, 1'b1, 32'h103);
      check("redir_pc",    fetch_pc,       32'h100);
      check("redir_count", 32'(count),     32'h0);
      check("redir_dv",    32'(deq_valid), 32'h0);
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 32'hF000_0000, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200 + 32'(i * 4 + 1));
      check("redir_hold_pc", fetch_pc, 32'h208);

      // Randomised traffic against the scoreboard.
      for (int i = 0; i < 400; i++)
         cycle($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 2,
               {$urandom_range(0, 16'hFFFF), 2'b00}, $urandom_range(0, 9) < 6,
               $urandom_range(0, 29) == 0, $urandom);
      for (int i = 0; i < 8; i++)
         cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      check("drained", 32'(sb.size()), 32'h0);

      // Reset beats redirect.
      start       = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h500;
      @(posedge clk);
      #1;
      start    = 1'b0;
      redirect = 1'b0;
      @(negedge clk);
      check("rst_over_redir_pc",    fetch_pc,   32'h0);
      check("rst_over_redir_count", 32'(count), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
